// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-beat Wishbone-style master port between instruction fetch and load/store,
// giving data priority while a streak limit lets a waiting fetch through.
module cpu_mem_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_adr_i,
  input  logic        if_abort_i,
  output logic [31:0] if_dat_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10, DRAIN = 2'b11} state_t;
  state_t state, nxt;
  logic [3:0] dstreak;
  logic pick_d, pick_i;
  always_comb begin
    pick_d = d_req_i && (!if_req_i || dstreak < 4'(MAX_DSTREAK));
    pick_i = !pick_d && if_req_i && !if_abort_i;
    nxt = state;
    unique case (state)
      IDLE:    nxt = pick_d ? GNT_D : pick_i ? GNT_I : IDLE;
      GNT_I:   nxt = m_ack_i ? IDLE : if_abort_i ? DRAIN : GNT_I;
      default: nxt = m_ack_i ? IDLE : state;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      dstreak <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick_d) begin
        m_we_o  <= d_we_i;
        m_sel_o <= d_sel_i;
        m_adr_o <= d_adr_i;
        m_dat_o <= d_dat_i;
        dstreak <= !if_req_i ? 4'd0 : dstreak == 4'(MAX_DSTREAK) ? dstreak : dstreak + 4'd1;
      end else if (state == IDLE && pick_i) begin
        m_we_o  <= 1'b0;
        m_sel_o <= 4'hF;
        m_adr_o <= if_adr_i;
        m_dat_o <= '0;
        dstreak <= '0;
      end
    end
  end
  // A fetch aborted in its ack cycle is dropped rather than delivered.
  assign if_ack_o = state == GNT_I && m_ack_i && !if_abort_i;
  assign d_ack_o  = state == GNT_D && m_ack_i;
  assign if_dat_o = m_dat_i;
  assign d_dat_o  = m_dat_i;
  assign m_cyc_o  = state != IDLE;
  assign m_stb_o  = m_cyc_o;
  assign grant_o  = state;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed cycle table for fetch/data sequencing plus hand sequences for
// streak limiting, abort drain, coincident abort and asynchronous reset.
module tb_cpu_mem_arbiter;
  logic clk_i = 0, rst_i = 1;
  logic if_req_i = 0, if_abort_i = 0, d_req_i = 0, d_we_i = 0, m_ack_i = 0;
  logic [31:0] if_adr_i = 0, d_adr_i = 0, d_dat_i = 0, m_dat_i = 0;
  logic [3:0] d_sel_i = 0;
  logic [31:0] if_dat_o, d_dat_o, m_adr_o, m_dat_o;
  logic if_ack_o, d_ack_o, m_cyc_o, m_stb_o, m_we_o;
  logic [3:0] m_sel_o;
  logic [1:0] grant_o;
  int ncmp = 0, nerr = 0;

  cpu_mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_abort_i(if_abort_i),
    .if_dat_o(if_dat_o), .if_ack_o(if_ack_o), .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .m_cyc_o(m_cyc_o),
    .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic ireq; logic [31:0] iadr; logic abt, dreq, dwe; logic [3:0] dsel;
    logic [31:0] dadr, ddat, mdat; logic mack;
    logic [1:0] g; logic cyc, we; logic [3:0] sel; logic [31:0] adr, wdat; logic iack, dack;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    logic [1:0] got[6];
    logic [1:0] exp_g[6];
    int ng;
    tv[0] = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0,
              2'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0,
              2'd1, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b0};
    tv[2] = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1,
              2'd1, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0,
              2'd0, 1'b0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b0};
    tv[4] = '{1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678, 32'h0, 1'b0,
              2'd0, 1'b0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 4'h3, 32'h2004, 32'hAAAAAAAA, 32'h0, 1'b0,
              2'd2, 1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678, 1'b0, 1'b0};
    tv[6] = '{1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678, 32'h0, 1'b1,
              2'd2, 1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678, 1'b0, 1'b1};
    tv[7] = '{1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0,
              2'd0, 1'b0, 1'b1, 4'h3, 32'h2000, 32'h12345678, 1'b0, 1'b0};
    tv[8] = '{1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b1,
              2'd1, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, 1'b1, 1'b0};
    tv[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0,
              2'd0, 1'b0, 1'b0, 4'hF, 32'h3000, 32'h0, 1'b0, 1'b0};
    exp_g = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};

    #7;
    chk("rst_grant", grant_o, 0); chk("rst_cyc", m_cyc_o, 0);
    chk("rst_adr", m_adr_o, 0); chk("rst_sel", m_sel_o, 0);
    @(negedge clk_i) rst_i = 0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if_req_i = tv[i].ireq; if_adr_i = tv[i].iadr; if_abort_i = tv[i].abt;
      d_req_i = tv[i].dreq; d_we_i = tv[i].dwe; d_sel_i = tv[i].dsel;
      d_adr_i = tv[i].dadr; d_dat_i = tv[i].ddat; m_dat_i = tv[i].mdat; m_ack_i = tv[i].mack;
      #1;
      chk($sformatf("v%0d_grant", i), grant_o, tv[i].g);
      chk($sformatf("v%0d_cyc", i), m_cyc_o, tv[i].cyc);
      chk($sformatf("v%0d_stb", i), m_stb_o, tv[i].cyc);
      chk($sformatf("v%0d_we", i), m_we_o, tv[i].we);
      chk($sformatf("v%0d_sel", i), m_sel_o, tv[i].sel);
      chk($sformatf("v%0d_adr", i), m_adr_o, tv[i].adr);
      chk($sformatf("v%0d_wdat", i), m_dat_o, tv[i].wdat);
      chk($sformatf("v%0d_iack", i), if_ack_o, tv[i].iack);
      chk($sformatf("v%0d_dack", i), d_ack_o, tv[i].dack);
      if (tv[i].iack) chk($sformatf("v%0d_idat", i), if_dat_o, tv[i].mdat);
      if (tv[i].dack) chk($sformatf("v%0d_ddat", i), d_dat_o, tv[i].mdat);
    end

    // Data and fetch requesting continuously: four data grants, one fetch, then data again.
    if_req_i = 1; if_adr_i = 32'h6000; d_req_i = 1; d_we_i = 0; d_adr_i = 32'h7000; d_sel_i = 4'hF;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge clk_i);
      m_ack_i = m_cyc_o;
      #1;
      if (m_cyc_o) begin
        got[ng] = grant_o;
        ng++;
      end
    end
    if_req_i = 0; d_req_i = 0;
    chk("starve_grants_seen", ng, 6);
    for (int i = 0; i < ng; i++) chk($sformatf("starve_g%0d", i), got[i], exp_g[i]);

    // Abort one cycle into a fetch grant; ack three cycles later drains it.
    @(negedge clk_i); m_ack_i = 0; if_req_i = 1; if_adr_i = 32'h4000; #1;
    chk("ab_idle", grant_o, 0);
    @(negedge clk_i); if_abort_i = 1; if_req_i = 0;
    d_req_i = 1; d_we_i = 0; d_adr_i = 32'h8000; d_sel_i = 4'hF; #1;
    chk("ab_gnt_i", grant_o, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); if_abort_i = 0; m_ack_i = (k == 2); #1;
      chk($sformatf("ab_drain_g%0d", k), grant_o, 3);
      chk($sformatf("ab_drain_cyc%0d", k), m_cyc_o, 1);
      chk($sformatf("ab_drain_iack%0d", k), if_ack_o, 0);
      chk($sformatf("ab_drain_dack%0d", k), d_ack_o, 0);
    end
    @(negedge clk_i); m_ack_i = 0; #1;
    chk("ab_back_idle", grant_o, 0); chk("ab_idle_cyc", m_cyc_o, 0);
    @(negedge clk_i); #1;
    chk("ab_then_data", grant_o, 2); chk("ab_data_adr", m_adr_o, 32'h8000);
    m_ack_i = 1; #1;
    chk("ab_data_ack", d_ack_o, 1);
    @(negedge clk_i); m_ack_i = 0; d_req_i = 0;

    // Abort arriving together with the bus ack.
    @(negedge clk_i); if_req_i = 1; if_adr_i = 32'h5000; #1;
    chk("co_idle", grant_o, 0);
    @(negedge clk_i); if_abort_i = 1; m_ack_i = 1; m_dat_i = 32'h11111111; #1;
    chk("co_gnt_i", grant_o, 1); chk("co_iack", if_ack_o, 0);
    @(negedge clk_i); if_abort_i = 0; m_ack_i = 0; if_req_i = 0; #1;
    chk("co_idle_after", grant_o, 0); chk("co_cyc_after", m_cyc_o, 0);

    // Asynchronous reset in the middle of a store.
    @(negedge clk_i); d_req_i = 1; d_we_i = 1; d_adr_i = 32'h9000; d_dat_i = 32'h55AA55AA; d_sel_i = 4'hC; #1;
    @(negedge clk_i); #1;
    chk("rs_gnt_d", grant_o, 2); chk("rs_cyc", m_cyc_o, 1);
    #2 rst_i = 1; m_ack_i = 1; #1;
    chk("rs_cyc0", m_cyc_o, 0); chk("rs_grant0", grant_o, 0);
    chk("rs_dack0", d_ack_o, 0); chk("rs_we0", m_we_o, 0); chk("rs_adr0", m_adr_o, 0);
    @(negedge clk_i); rst_i = 0; m_ack_i = 0; d_req_i = 0;
    @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
